div_share_ctrl: RTL and testbench

- Controller and round-robin arbiter that shares one sequential N-bit divider among NREQ requesters.
- Accepts one request at a time with a valid/ready handshake, then launches the divider with a one-cycle start pulse and waits for its done flag.
- Returns quotient and remainder tagged with the requester ID.
- Divide-by-zero is resolved locally without using the divider. A watchdog aborts a divider that never completes.

---
 rtl/div_share_ctrl.sv | 152 +++++++++++++++
 tb/tb_div_share_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin controller sharing one sequential divider among NREQ requesters.
// Rev 1.0 - divide-by-zero answered locally, watchdog aborts a stalled divide.
`default_nettype none

module div_share_ctrl #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_dividend,
  input  logic [NREQ*N-1:0]   req_divisor,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [N-1:0]        rsp_quotient,
  output logic [N-1:0]        rsp_remainder,
  output logic [1:0]          rsp_err,
  output logic                div_start,
  output logic [N-1:0]        div_dividend,
  output logic [N-1:0]        div_divisor,
  input  logic                div_done,
  input  logic [N-1:0]        div_quotient,
  input  logic [N-1:0]        div_remainder,
  output logic                busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_ptr;
  logic [TW-1:0]   r_timer;
  logic [IDW-1:0]  r_id;
  logic [N-1:0]    r_quot;
  logic [N-1:0]    r_rem;
  logic [1:0]      r_err;
  logic [N-1:0]    r_dvd;
  logic [N-1:0]    r_dvs;

  logic            w_found;
  logic [IDW-1:0]  w_gid;
  logic [NREQ-1:0] w_grant;
  logic            w_accept;
  logic [N-1:0]    w_dvd;
  logic [N-1:0]    w_dvs;
  logic            w_timeout;

  // Search starts just after the last winner so it drops to lowest priority.
  always_comb begin : p_arb
    logic [IDW-1:0] idx;
    w_found = 1'b0;
    w_gid   = '0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = r_ptr + IDW'(i);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gid   = idx;
      end
    end
  end

  assign w_grant   = w_found ? (NREQ'(1) << w_gid) : '0;
  assign req_ready = (rst_n && (r_state == S_IDLE)) ? w_grant : '0;
  assign w_accept  = (r_state == S_IDLE) && w_found;
  assign w_dvd     = req_dividend[w_gid*N +: N];
  assign w_dvs     = req_divisor[w_gid*N +: N];
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= IDW'(NREQ - 1);
      r_timer <= '0;
      r_id    <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_err   <= ERR_OK;
      r_dvd   <= '0;
      r_dvs   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ptr <= w_gid;
            r_id  <= w_gid;
            r_dvd <= w_dvd;
            r_dvs <= w_dvs;
            if (w_dvs == '0) begin
              r_quot  <= '1;
              r_rem   <= w_dvd;
              r_err   <= ERR_DIV0;
              r_state <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the last allowed cycle still counts as success.
          if (div_done) begin
            r_quot  <= div_quotient;
            r_rem   <= div_remainder;
            r_err   <= ERR_OK;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_err   <= ERR_TMO;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_start     = (r_state == S_ISSUE);
  assign div_dividend  = r_dvd;
  assign div_divisor   = r_dvs;
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_id        = r_id;
  assign rsp_quotient  = r_quot;
  assign rsp_remainder = r_rem;
  assign rsp_err       = r_err;
  assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: vector table, hand sequences and random traffic against a transaction-level model.
// Rev 1.0
`default_nettype none

module tb_div_share_ctrl;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_quotient;
  logic [7:0]  rsp_remainder;
  logic [1:0]  rsp_err;
  logic        div_start;
  logic [7:0]  div_dividend;
  logic [7:0]  div_divisor;
  logic        div_done;
  logic [7:0]  div_quotient;
  logic [7:0]  div_remainder;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int m_ptr = 3;

  int   dv_lat = 1;
  int   dv_cnt = 0;
  bit   dv_hang = 1'b0;
  logic [7:0] dv_a, dv_b;

  div_share_ctrl #(.N(8), .NREQ(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider stand-in: done pulses dv_lat cycles after the start cycle; results are junk otherwise.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_cnt = 0;
      div_done = 1'b0;
      div_quotient = '0;
      div_remainder = '0;
    end else begin
      div_done = 1'b0;
      div_quotient = 8'($urandom);
      div_remainder = 8'($urandom);
      if (div_start) begin
        dv_cnt = dv_hang ? 0 : dv_lat;
        dv_a = div_dividend;
        dv_b = div_divisor;
      end else if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          div_done = 1'b1;
          div_quotient = dv_a / dv_b;
          div_remainder = dv_a % dv_b;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic chk_zero(input string name);
    check(name, {req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
                 div_start, div_dividend, div_divisor, busy}, 64'd0);
  endtask

  function automatic int model_grant(input logic [3:0] m);
    for (int i = 1; i <= 4; i++)
      if (m[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    return 0;
  endfunction

  task automatic txn(input logic [3:0] mask, input logic [31:0] dvd, input logic [31:0] dvs,
                     input int lat, input bit hang, input int bp, input int eid,
                     input int eq, input int er, input int ee, input int elat);
    logic [3:0] eg;
    logic [7:0] ea, eb;
    int w, t0, starts;
    eg = 4'b0001 << eid;
    ea = dvd[eid*8 +: 8];
    eb = dvs[eid*8 +: 8];
    dv_lat = lat;
    dv_hang = hang;
    req_dividend = dvd;
    req_divisor = dvs;
    req_valid = mask;
    #1;
    w = 0;
    while (req_ready == 4'b0 && w < 20) begin @(negedge clk); #1; w++; end
    check("grant", req_ready, eg);
    if (req_ready != eg) begin req_valid = '0; return; end
    m_ptr = eid;
    t0 = cyc;
    @(negedge clk); #1;
    req_valid = '0;
    starts = 0;
    w = 0;
    while (!rsp_valid && w < 100) begin
      if (div_start) begin
        starts++;
        check("operands", {div_dividend, div_divisor}, {ea, eb});
      end
      check("busy_no_grant", {busy, req_ready}, {1'b1, 4'b0});
      @(negedge clk); #1;
      w++;
    end
    check("rsp_valid", rsp_valid, 1);
    if (!rsp_valid) return;
    check("latency", cyc - t0, elat);
    check("start_count", starts, (ee == 1) ? 0 : 1);
    check("rsp_fields", {rsp_id, rsp_quotient, rsp_remainder, rsp_err},
          {2'(eid), 8'(eq), 8'(er), 2'(ee)});
    for (int d = 0; d < bp; d++) begin
      req_valid = 4'hF;
      @(negedge clk); #1;
      check("backpressure_hold", {rsp_valid, req_ready, rsp_id, rsp_quotient, rsp_remainder, rsp_err},
            {1'b1, 4'b0, 2'(eid), 8'(eq), 8'(er), 2'(ee)});
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", {rsp_valid, busy}, 2'b00);
  endtask

  typedef struct {
    int id; int a; int b; int lat; bit hang; int bp;
    int eq; int er; int ee; int elat;
  } vec_t;

  vec_t tbl[9];
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int rsp_q[$];

  initial begin
    logic [3:0]  mask;
    logic [31:0] dvd, dvs;
    int eid, a, b, lat, bp, eq, er, ee, el, ng, nr, cycles, id;
    bit hang;

    tbl[0] = '{0, 100, 7, 3, 1'b0, 0, 14, 2, 0, 5};
    tbl[1] = '{2, 55, 0, 1, 1'b0, 0, 255, 55, 1, 1};
    tbl[2] = '{1, 200, 3, 1, 1'b0, 0, 66, 2, 0, 3};
    tbl[3] = '{3, 9, 10, 2, 1'b0, 0, 0, 9, 0, 4};
    tbl[4] = '{0, 77, 5, 1, 1'b1, 0, 0, 0, 2, 10};
    tbl[5] = '{1, 255, 1, 1, 1'b0, 0, 255, 0, 0, 3};
    tbl[6] = '{2, 50, 6, 4, 1'b0, 5, 8, 2, 0, 6};
    tbl[7] = '{3, 90, 9, 8, 1'b0, 0, 10, 0, 0, 10};
    tbl[8] = '{0, 91, 9, 9, 1'b0, 0, 0, 0, 2, 10};

    rst_n = 1'b0;
    req_valid = 4'hF;
    req_dividend = 32'h11223344;
    req_divisor = 32'h01020304;
    rsp_ready = 1'b0;
    #3;
    chk_zero("reset_outputs");
    req_valid = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Round-robin with all requesters asserting continuously.
    req_dividend = {8'd99, 8'd61, 8'd47, 8'd20};
    req_divisor  = {8'd5, 8'd4, 8'd3, 8'd6};
    dv_lat = 3;
    dv_hang = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    ng = 0; nr = 0; cycles = 0;
    #1;
    while (nr < 5 && cycles < 300) begin
      if (ng == 5) req_valid = '0;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rr_extra_rsp", rsp_valid, 0);
        else begin
          id = rsp_q.pop_front();
          check("rr_rsp", {rsp_id, rsp_quotient, rsp_remainder, rsp_err},
                {2'(id), req_dividend[id*8 +: 8] / req_divisor[id*8 +: 8],
                 req_dividend[id*8 +: 8] % req_divisor[id*8 +: 8], 2'b00});
          nr++;
        end
      end
      if (req_ready != 4'b0 && ng < 5) begin
        check("rr_onehot", $onehot(req_ready), 1);
        check("rr_order", req_ready, 4'b0001 << rr_exp[ng]);
        m_ptr = rr_exp[ng];
        rsp_q.push_back(rr_exp[ng]);
        ng++;
      end
      @(negedge clk); #1;
      cycles++;
    end
    check("rr_complete", nr, 5);
    req_valid = '0;
    rsp_ready = 1'b0;

    for (int i = 0; i < 9; i++)
      txn(4'b0001 << tbl[i].id, 32'(tbl[i].a) << (tbl[i].id * 8), 32'(tbl[i].b) << (tbl[i].id * 8),
          tbl[i].lat, tbl[i].hang, tbl[i].bp, tbl[i].id,
          tbl[i].eq, tbl[i].er, tbl[i].ee, tbl[i].elat);

    // Reset while the divider is in flight.
    dv_hang = 1'b1;
    req_dividend = 32'(60) << 8;
    req_divisor  = 32'(7) << 8;
    req_valid = 4'b0010;
    #1;
    cycles = 0;
    while (req_ready == 4'b0 && cycles < 20) begin @(negedge clk); #1; cycles++; end
    check("rstw_grant", req_ready, 4'b0010);
    m_ptr = 1;
    @(negedge clk); #1;
    req_valid = '0;
    check("rstw_start", div_start, 1);
    @(negedge clk); @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_dividend = {8'd33, 8'd0, 8'd60, 8'd0};
    req_divisor  = {8'd4, 8'd0, 8'd7, 8'd0};
    req_valid = 4'b1010;
    #1;
    chk_zero("rstw_async_zero");
    m_ptr = 3;
    @(negedge clk); #1;
    chk_zero("rstw_held_zero");
    rst_n = 1'b1;
    #1;
    check("rstw_lowest_grant", req_ready, 4'b0010);
    txn(4'b1010, req_dividend, req_divisor, 2, 1'b0, 0, model_grant(4'b1010), 8, 4, 0, 4);

    for (int k = 0; k < 40; k++) begin
      mask = 4'($urandom_range(1, 15));
      dvd = $urandom;
      dvs = $urandom;
      for (int s = 0; s < 4; s++)
        if ($urandom_range(0, 5) == 0) dvs[s*8 +: 8] = 8'd0;
      lat = $urandom_range(1, 10);
      hang = ($urandom_range(0, 9) == 0);
      bp = $urandom_range(0, 2);
      eid = model_grant(mask);
      a = int'(dvd[eid*8 +: 8]);
      b = int'(dvs[eid*8 +: 8]);
      if (b == 0) begin
        eq = 255; er = a; ee = 1; el = 1;
      end else if (hang || lat > TIMEOUT) begin
        eq = 0; er = 0; ee = 2; el = 2 + TIMEOUT;
      end else begin
        eq = a / b; er = a % b; ee = 0; el = 2 + lat;
      end
      txn(mask, dvd, dvs, lat, hang, bp, eid, eq, er, ee, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

`default_nettype wire
